shared_reg_arbiter: RTL and testbench
=====================================

// Module: shared_reg_arbiter
// PURPOSE
//  Round-robin arbiter/sequencer for one shared always_ff register (a_q).
//  N_REQ requesters each present req + wdata; the block grants one at a time,
//  performs the registered write a_q <= wdata[winner] and returns a one-cycle ack.
//  Sits between requester logic and the shared state register.
// PARAMETERS
//  N_REQ     4  number of requesters (2..16)
//  WIDTH     8  width of shared register and each wdata slice
//  HOLD_MAX  4  max consecutive locked writes per grant (ARB_LOCK_EN only; >=1)
// PORTS
//  clk     in   1            clock, all state on posedge clk
//  rst_n   in   1            asynchronous, active-low reset
//  req     in   N_REQ        per-requester write request, level
//  wdata   in   N_REQ*WIDTH  slice i = wdata[i*WIDTH +: WIDTH]
//  lock    in   N_REQ        keep grant for further writes (ARB_LOCK_EN only)
//  gnt     out  N_REQ        one-hot grant, registered
//  ack     out  N_REQ        one-hot, 1-cycle pulse: write committed
//  a_q     out  WIDTH        shared register value
//  a_valid out  1            set by first committed write, sticky until reset
//  busy    out  1            state != IDLE
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, gnt=0, ack=0, a_q=0, a_valid=0,
//   rr_ptr=0, hold_cnt=0. Reset mid-grant aborts without ack or write.
//  States: IDLE, GRANT.
//  IDLE: if |req: winner = first set req at/after rr_ptr (wrapping N_REQ-1->0);
//   gnt <= onehot(winner); -> GRANT. Else stay, gnt=0.
//  GRANT (one cycle): if req[winner]=1: a_q <= wdata slice, a_valid <= 1,
//   ack <= onehot(winner), gnt <= 0, rr_ptr <= (winner+1) mod N_REQ, -> IDLE.
//   If req[winner]=0 (withdrawn): no write, no ack, gnt <= 0, rr_ptr
//   unchanged, -> IDLE.
//  Latency: req seen in IDLE at cycle 0 -> gnt cycle 1 -> a_q/ack cycle 2.
//   Back-to-back: max one write per 2 cycles; next arbitration uses updated
//   rr_ptr in the cycle ack is high.
//  Requester holds req and wdata stable from req assertion until ack; wdata
//   sampled only in GRANT. Req in ack cycle counts as a new request.
//  Simultaneous reqs: only the rr winner is served; others wait, no starvation
//   (each waits at most N_REQ-1 grants, or (N_REQ-1)*HOLD_MAX writes w/ lock).
//  ack and gnt never high together; gnt, ack always zero- or one-hot.
// CONFIGURATION
//  SHARED_REG_ARB_LOCK_EN defined: in GRANT, on a committed write with
//   lock[winner]=1 and hold_cnt < HOLD_MAX-1: hold_cnt++, gnt held, state stays
//   GRANT, rr_ptr not advanced; one write+ack per cycle. Release (normal GRANT
//   exit, hold_cnt <= 0) when lock=0, req=0, or hold_cnt reaches HOLD_MAX-1.
//  Not defined: lock input ignored (unconnected allowed), hold_cnt absent,
//   behaviour exactly as in BEHAVIOUR.
// TESTING
//  T1 reset: rst_n=0 mid-GRANT -> gnt=0, ack=0, a_q=0, a_valid=0 immediately.
//  T2 single: req=4'b0010, slice1=8'hA5 at cyc0 -> gnt=0010 cyc1, a_q=8'hA5,
//     ack=0010, a_valid=1 cyc2.
//  T3 fairness: req=4'b1111 held, distinct data -> acks 0001,0010,0100,1000,
//     0001 on alternating cycles; a_q tracks each slice.
//  T4 withdraw: req=0100 at cyc0, dropped cyc1 -> no ack, a_q unchanged,
//     next req=1100 grants requester 2 first (rr_ptr unchanged).
//  T5 wrap: rr_ptr=3 after ack to 2, req=1001 -> requester 3 first, then 0.
//  T6 (LOCK_EN, HOLD_MAX=4) req=lock=0001 held, req=0010 -> requester 0 gets 4
//     consecutive acks, then requester 1 granted; without macro alternates.

Source files
------------

// File: rtl/shared_reg_arbiter_if.sv
// Bundle between requesters and the shared-register arbiter.
// The slave modport is the arbiter side; the master modport is the requester side.
interface shared_reg_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int WIDTH = 8
);
   logic [N_REQ-1:0]       req;
   logic [N_REQ*WIDTH-1:0] wdata;
   logic [N_REQ-1:0]       lock;
   logic [N_REQ-1:0]       gnt;
   logic [N_REQ-1:0]       ack;
   logic [WIDTH-1:0]       a_q;
   logic                   a_valid;
   logic                   busy;

   modport slave (
      input  req, wdata, lock,
      output gnt, ack, a_q, a_valid, busy
   );

   modport master (
      output req, wdata, lock,
      input  gnt, ack, a_q, a_valid, busy
   );
endinterface

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter that serialises writes from N_REQ requesters into one shared register.
// Optional macro SHARED_REG_ARB_LOCK_EN lets a locked winner keep the grant for up to HOLD_MAX writes.
//
// state | meaning
// IDLE  | no grant outstanding; arbitrate among pending requests
// GRANT | winner holds gnt; commit its write (or drop it if req withdrawn)
module shared_reg_arbiter #(
   parameter int N_REQ    = 4,
   parameter int WIDTH    = 8,
   parameter int HOLD_MAX = 4
) (
   input  logic clk,
   input  logic rst_n,
   shared_reg_arbiter_if.slave bus
);
   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [N_REQ-1:0] ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  rr_ptr;
   logic [IDX_W-1:0]  win;
   logic [IDX_W-1:0]  pick;
   logic [IDX_W-1:0]  win_next;
   logic [N_REQ-1:0]  gnt_q;
   logic [N_REQ-1:0]  ack_q;
   logic [WIDTH-1:0]  a_q_r;
   logic              a_valid_r;
   logic [WIDTH-1:0]  win_data;

`ifdef SHARED_REG_ARB_LOCK_EN
   localparam int HC_W = $clog2(HOLD_MAX) + 1;
   logic [HC_W-1:0]   hold_cnt;
   logic              keep;
`else
   logic              unused_lock;
   assign unused_lock = |bus.lock;
`endif

   // First pending request at or after rr_ptr, wrapping to 0.
   always_comb begin
      int  idx;
      logic found;
      pick  = rr_ptr;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(rr_ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            pick  = IDX_W'(idx);
         end
      end
   end

   assign win_next = (win == IDX_W'(N_REQ - 1)) ? '0 : win + 1'b1;
   assign win_data = bus.wdata[int'(win)*WIDTH +: WIDTH];

`ifdef SHARED_REG_ARB_LOCK_EN
   assign keep = bus.lock[win] && (hold_cnt < HC_W'(HOLD_MAX - 1));
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         rr_ptr    <= '0;
         win       <= '0;
         gnt_q     <= '0;
         ack_q     <= '0;
         a_q_r     <= '0;
         a_valid_r <= 1'b0;
`ifdef SHARED_REG_ARB_LOCK_EN
         hold_cnt  <= '0;
`endif
      end else begin
         ack_q <= '0;
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  win   <= pick;
                  gnt_q <= ONE << pick;
                  state <= GRANT;
               end else begin
                  gnt_q <= '0;
               end
            end
            GRANT: begin
               if (bus.req[win]) begin
                  a_q_r     <= win_data;
                  a_valid_r <= 1'b1;
                  ack_q     <= ONE << win;
`ifdef SHARED_REG_ARB_LOCK_EN
                  if (keep) begin
                     hold_cnt <= hold_cnt + 1'b1;
                  end else begin
                     hold_cnt <= '0;
                     gnt_q    <= '0;
                     rr_ptr   <= win_next;
                     state    <= IDLE;
                  end
`else
                  gnt_q  <= '0;
                  rr_ptr <= win_next;
                  state  <= IDLE;
`endif
               end else begin
                  // Withdrawn request: pointer stays so the same requester keeps priority.
                  gnt_q <= '0;
                  state <= IDLE;
`ifdef SHARED_REG_ARB_LOCK_EN
                  hold_cnt <= '0;
`endif
               end
            end
            default: begin
               gnt_q <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.gnt     = gnt_q;
   assign bus.ack     = ack_q;
   assign bus.a_q     = a_q_r;
   assign bus.a_valid = a_valid_r;
   assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Scoreboard bench for shared_reg_arbiter: stimulus pushes expected acks, a negedge monitor pops and compares.
module tb_shared_reg_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   shared_reg_arbiter_if #(.N_REQ(4), .WIDTH(8)) bus ();

   shared_reg_arbiter #(.N_REQ(4), .WIDTH(8), .HOLD_MAX(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   typedef struct {
      logic [3:0] ack;
      logic [7:0] data;
   } exp_t;

   exp_t q[$];
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [3:0] a, input logic [7:0] d);
      exp_t e;
      e.ack  = a;
      e.data = d;
      q.push_back(e);
   endtask

   // Wait until the monitor has consumed every expected ack; leaves time just after a negedge.
   task automatic drain(input string name);
      int n;
      n = 0;
      while (q.size() != 0 && n < 60) begin
         @(negedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_timeout: got %0d pending acks expected 0", name, q.size());
         q.delete();
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && bus.ack != 4'b0000) begin
            if (q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_ack: got %b expected none", bus.ack);
            end else begin
               e = q.pop_front();
               check("ack", 32'(bus.ack), 32'(e.ack));
               check("a_q", 32'(bus.a_q), 32'(e.data));
               check("a_valid", 32'(bus.a_valid), 32'd1);
`ifndef SHARED_REG_ARB_LOCK_EN
               check("gnt_ack_excl", 32'(bus.gnt & bus.ack), 32'd0);
`endif
            end
         end
      end
   end

   initial begin
      bus.req   = '0;
      bus.wdata = '0;
      bus.lock  = '0;

      // T1: reset values, then reset while a grant is outstanding
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'(bus.gnt), 32'd0);
      check("rst_ack", 32'(bus.ack), 32'd0);
      check("rst_a_q", 32'(bus.a_q), 32'd0);
      check("rst_a_valid", 32'(bus.a_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      bus.req   = 4'b0010;
      bus.wdata = {8'h00, 8'h00, 8'h5A, 8'h00};
      @(posedge clk);
      #1;
      check("t1_gnt", 32'(bus.gnt), 32'b0010);
      #2;
      rst_n = 1'b0;
      #1;
      check("t1_abort_gnt", 32'(bus.gnt), 32'd0);
      check("t1_abort_ack", 32'(bus.ack), 32'd0);
      check("t1_abort_a_q", 32'(bus.a_q), 32'd0);
      check("t1_abort_a_valid", 32'(bus.a_valid), 32'd0);
      bus.req = '0;
      @(negedge clk);
      rst_n = 1'b1;

      // T2: single request, latency gnt at +1 and ack at +2
      @(negedge clk);
      push(4'b0010, 8'hA5);
      bus.req   = 4'b0010;
      bus.wdata = {8'h00, 8'h00, 8'hA5, 8'h00};
      @(posedge clk);
      #1;
      check("t2_gnt", 32'(bus.gnt), 32'b0010);
      check("t2_busy", 32'(bus.busy), 32'd1);
      check("t2_no_ack_yet", 32'(bus.ack), 32'd0);
      drain("t2");
      bus.req = '0;

      // Reset so fairness starts from pointer 0
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("t3_pre_a_valid", 32'(bus.a_valid), 32'd0);

      // T3: all four request, round-robin order
      push(4'b0001, 8'h11);
      push(4'b0010, 8'h22);
      push(4'b0100, 8'h33);
      push(4'b1000, 8'h44);
      push(4'b0001, 8'h11);
      bus.wdata = {8'h44, 8'h33, 8'h22, 8'h11};
      bus.req   = 4'b1111;
      drain("t3");
      bus.req = '0;
      @(negedge clk);

      // T4: withdrawn request produces nothing and keeps the pointer at 1
      bus.req   = 4'b0100;
      bus.wdata = {8'h00, 8'hCC, 8'h00, 8'h00};
      @(posedge clk);
      #1;
      check("t4_gnt", 32'(bus.gnt), 32'b0100);
      bus.req = '0;
      @(posedge clk);
      #1;
      check("t4_no_ack", 32'(bus.ack), 32'd0);
      check("t4_a_q_kept", 32'(bus.a_q), 32'h11);
      check("t4_gnt_clear", 32'(bus.gnt), 32'd0);
      @(negedge clk);
      push(4'b0100, 8'h55);
      push(4'b1000, 8'h66);
      bus.wdata = {8'h66, 8'h55, 8'h00, 8'h00};
      bus.req   = 4'b1100;
      drain("t4");
      bus.req = '0;
      @(negedge clk);

      // T5: ack to 2 moves pointer to 3, then 3 wins over 0
      push(4'b0100, 8'h77);
      bus.wdata = {8'h00, 8'h77, 8'h00, 8'h00};
      bus.req   = 4'b0100;
      drain("t5a");
      bus.req = '0;
      @(negedge clk);
      push(4'b1000, 8'h99);
      push(4'b0001, 8'h88);
      bus.wdata = {8'h99, 8'h00, 8'h00, 8'h88};
      bus.req   = 4'b1001;
      drain("t5b");
      bus.req = '0;
      @(negedge clk);

      // T6: requester 0 asserts lock; pointer is at 1
      push(4'b0010, 8'hB1);
`ifdef SHARED_REG_ARB_LOCK_EN
      repeat (4) push(4'b0001, 8'hA0);
`else
      push(4'b0001, 8'hA0);
      push(4'b0010, 8'hB1);
      push(4'b0001, 8'hA0);
`endif
      bus.wdata = {8'h00, 8'h00, 8'hB1, 8'hA0};
      bus.lock  = 4'b0001;
      bus.req   = 4'b0011;
      drain("t6");
      bus.req  = '0;
      bus.lock = '0;

      repeat (5) @(negedge clk);
      check("final_busy", 32'(bus.busy), 32'd0);
      check("queue_empty", 32'(q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
